vend_credit_sequencer: RTL
==========================

Name: vend_credit_sequencer

Overview:
- Top-level controller for a multi-product vending machine. It sits between the coin acceptor, the selection keypad, the product dispenser and the single-coin change hopper.
- Accumulates credit in 5tk units, checks each selection against a per-product price, sequences the dispense handshake, then pays out change one 5tk coin at a time.
- Replaces per-price hard-coded state machines with one parameterised credit/price datapath.

Parameters:
- CREDIT_W, 4, credit register width in 5tk units; max credit CREDIT_MAX = 2^CREDIT_W-1.
- PRICE0, 3, price of product 0 in 5tk units (15tk).
- PRICE1, 2, price of product 1 in 5tk units.
- PRICE2, 4, price of product 2 in 5tk units.
- PRICE3, 6, price of product 3 in 5tk units.
- TIMEOUT_CYCLES, 1000, idle cycles in COLLECT before auto-refund (used only with VEND_TIMEOUT_EN).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- coin_valid  in  1  coin acceptor presents a coin
- coin_code  in  2  01=5tk (1 unit), 10=10tk (2 units), 11=20tk (4 units), 00=invalid
- coin_ready  out  1  controller accepts coin this cycle
- sel_valid  in  1  one-cycle selection strobe
- sel_id  in  2  selected product
- cancel  in  1  one-cycle refund request
- sel_deny  out  1  one-cycle pulse: selection rejected, insufficient credit
- disp_req  out  1  dispense request, level
- disp_id  out  2  product being dispensed
- disp_done  in  1  dispenser completion strobe
- vend_ok  out  1  one-cycle pulse on completed vend
- chg_req  out  1  request one 5tk change coin, level
- chg_ack  in  1  hopper ejected one coin
- credit  out  CREDIT_W  current credit in 5tk units
- busy  out  1  state is DISPENSE or CHANGE

Behaviour:
- Reset (synchronous, active-high on clock): state=IDLE, credit=0, disp_id=0, all 1-bit outputs 0. Reset in any state, including mid-handshake, wins. The next cycle is IDLE with disp_req=chg_req=0, and any pending credit is discarded.
- States: IDLE, COLLECT, DISPENSE, CHANGE.
- coin_ready (combinational) = state in {IDLE, COLLECT} && !sel_valid && !cancel && credit <= CREDIT_MAX-4.
- A coin is accepted on coin_valid && coin_ready && coin_code != 00. Then credit += unit value, effective next cycle. Code 00 is consumed with no credit change.
- IDLE: accepted coin -> COLLECT. sel_valid and cancel are ignored, with no sel_deny.
- COLLECT, sel_valid:
  - credit >= PRICE[sel_id]: credit -= price, disp_id <= sel_id, -> DISPENSE.
  - otherwise: sel_deny=1 for 1 cycle, credit unchanged, stay.
  - Price 0 is legal (free vend).
- COLLECT, cancel (lower priority than sel_valid if both are asserted): -> CHANGE. If credit=0, go straight to IDLE.
- DISPENSE: disp_req=1 from the first DISPENSE cycle until the cycle disp_done is sampled high. On disp_done: vend_ok=1 for 1 cycle; -> CHANGE if credit>0, else IDLE. cancel, sel_valid and coins are ignored.
- CHANGE:
  - chg_req = (credit != 0).
  - Each cycle with chg_req && chg_ack: credit -= 1.
  - When credit reaches 0, -> IDLE the next cycle, with chg_req low in that cycle.
  - chg_ack while chg_req=0 is ignored.
- disp_done outside DISPENSE is ignored.
- credit never underflows or overflows (guaranteed by the coin_ready and price checks).
- Latency: selection strobe to disp_req = 1 cycle. disp_done to first chg_req = 1 cycle.

Optional Feature:
- Macro VEND_TIMEOUT_EN.
- Defined:
  - A counter (width clog2(TIMEOUT_CYCLES+1)) runs in COLLECT and clears on each accepted coin or on entry to COLLECT.
  - On reaching TIMEOUT_CYCLES with no sel_valid or cancel in that cycle: -> CHANGE, full refund of credit.
  - The counter is held at 0 outside COLLECT and by reset.
- Undefined: no counter; COLLECT waits indefinitely.

Test Plan:
- Exact payment: reset; coin 10 (code 10), coin 5 (code 01) -> credit=3. sel_id=0 -> disp_req=1, disp_id=0, credit=0. disp_done -> vend_ok pulse, IDLE, chg_req never asserted.
- Change: coin 20 -> credit=4. sel_id=1 -> credit=2, dispense. disp_done -> chg_req=1; two chg_ack (second delayed 3 cycles) -> credit 2->1->0, IDLE.
- Insufficient: coin 5 -> credit=1. sel_id=2 -> sel_deny 1-cycle pulse, credit=1, state COLLECT, disp_req=0.
- Cancel and overflow guard: coins to credit=11 -> coin_ready=1. One more 5tk -> credit=12, coin_ready=0, held coin not accepted. cancel -> 12 chg_ack handshakes, IDLE with credit=0.
- Reset mid-operation: assert reset in DISPENSE (disp_req=1) and again in CHANGE with credit=3 -> next cycle IDLE, credit=0, disp_req=chg_req=0. Later disp_done has no effect.
- VEND_TIMEOUT_EN, TIMEOUT_CYCLES=8: coin 10 then 8 idle cycles -> CHANGE, 2 change handshakes. A coin at cycle 5 restarts the count.

Source files
------------

// File: rtl/vend_credit_sequencer.sv
// Vending credit/price sequencer: accumulates coin credit, vends on sufficient credit, pays change one coin at a time.
// Latency: selection to disp_req 1 cycle; disp_done to first chg_req 1 cycle; sel_deny/vend_ok are registered pulses, one cycle after their cause.
// Backpressure: coin_ready drops outside IDLE/COLLECT, while sel_valid/cancel are up, or when one more 20tk coin could overflow credit.
//
// Ports: clock/reset (sync, active-high); coin_valid/coin_code/coin_ready coin acceptor handshake;
//   sel_valid/sel_id/cancel keypad; sel_deny rejection pulse; disp_req/disp_id/disp_done dispenser handshake;
//   vend_ok completion pulse; chg_req/chg_ack change hopper handshake; credit in 5tk units; busy in DISPENSE/CHANGE.
// Optional: define VEND_TIMEOUT_EN to refund automatically after TIMEOUT_CYCLES idle cycles in COLLECT.
module vend_credit_sequencer #(
  parameter int CREDIT_W       = 4,
  parameter int PRICE0         = 3,
  parameter int PRICE1         = 2,
  parameter int PRICE2         = 4,
  parameter int PRICE3         = 6,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_code,
  output logic                coin_ready,
  input  logic                sel_valid,
  input  logic [1:0]          sel_id,
  input  logic                cancel,
  output logic                sel_deny,
  output logic                disp_req,
  output logic [1:0]          disp_id,
  input  logic                disp_done,
  output logic                vend_ok,
  output logic                chg_req,
  input  logic                chg_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_COLLECT  = 2'd1;
  localparam logic [1:0] ST_DISPENSE = 2'd2;
  localparam logic [1:0] ST_CHANGE   = 2'd3;

  localparam logic [CREDIT_W-1:0] CREDIT_MAX = {CREDIT_W{1'b1}};
  // Largest credit that can still take a 20tk (4 unit) coin without wrapping.
  localparam logic [CREDIT_W-1:0] COIN_LIMIT = CREDIT_MAX - CREDIT_W'(4);
  localparam logic [CREDIT_W-1:0] P0 = CREDIT_W'(PRICE0);
  localparam logic [CREDIT_W-1:0] P1 = CREDIT_W'(PRICE1);
  localparam logic [CREDIT_W-1:0] P2 = CREDIT_W'(PRICE2);
  localparam logic [CREDIT_W-1:0] P3 = CREDIT_W'(PRICE3);

  logic [1:0]          state, state_nxt;
  logic [CREDIT_W-1:0] credit_nxt;
  logic [1:0]          disp_id_nxt;
  logic                sel_deny_nxt, vend_ok_nxt;
  logic [CREDIT_W-1:0] price_sel, coin_units;
  logic                coin_acc, timeout_hit;

  always_comb begin
    price_sel = P0;
    case (sel_id)
      2'd0: price_sel = P0;
      2'd1: price_sel = P1;
      2'd2: price_sel = P2;
      2'd3: price_sel = P3;
      default: price_sel = P0;
    endcase
  end

  always_comb begin
    coin_units = '0;
    case (coin_code)
      2'b01: coin_units = CREDIT_W'(1);
      2'b10: coin_units = CREDIT_W'(2);
      2'b11: coin_units = CREDIT_W'(4);
      default: coin_units = '0;
    endcase
  end

  assign coin_ready = ((state == ST_IDLE) || (state == ST_COLLECT)) && !sel_valid && !cancel
                      && (credit <= COIN_LIMIT);
  // Code 00 is still consumed by the acceptor; it simply adds nothing.
  assign coin_acc   = coin_valid && coin_ready && (coin_code != 2'b00);

`ifdef VEND_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES);
  logic [TO_W-1:0] to_cnt;

  // Cleared whenever the next state is not COLLECT, so every entry starts from zero.
  always_ff @(posedge clock) begin
    if (reset || (state_nxt != ST_COLLECT) || coin_acc) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_LAST) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  assign timeout_hit = (state == ST_COLLECT) && (to_cnt == TO_LAST) && !sel_valid && !cancel && !coin_acc;
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    credit_nxt   = credit;
    disp_id_nxt  = disp_id;
    sel_deny_nxt = 1'b0;
    vend_ok_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (coin_acc) begin
          credit_nxt = credit + coin_units;
          state_nxt  = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        // coin_ready is low while sel_valid/cancel are up, so no coin can race these branches.
        if (sel_valid) begin
          if (credit >= price_sel) begin
            credit_nxt  = credit - price_sel;
            disp_id_nxt = sel_id;
            state_nxt   = ST_DISPENSE;
          end else begin
            sel_deny_nxt = 1'b1;
          end
        end else if (cancel || timeout_hit) begin
          state_nxt = (credit != '0) ? ST_CHANGE : ST_IDLE;
        end else if (coin_acc) begin
          credit_nxt = credit + coin_units;
        end
      end
      ST_DISPENSE: begin
        if (disp_done) begin
          vend_ok_nxt = 1'b1;
          state_nxt   = (credit != '0) ? ST_CHANGE : ST_IDLE;
        end
      end
      ST_CHANGE: begin
        if (credit == '0) begin
          state_nxt = ST_IDLE;
        end else if (chg_ack) begin
          credit_nxt = credit - CREDIT_W'(1);
          // Leave on the last coin so chg_req is already low in the following cycle.
          if (credit == CREDIT_W'(1)) begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      credit   <= '0;
      disp_id  <= 2'd0;
      sel_deny <= 1'b0;
      vend_ok  <= 1'b0;
    end else begin
      state    <= state_nxt;
      credit   <= credit_nxt;
      disp_id  <= disp_id_nxt;
      sel_deny <= sel_deny_nxt;
      vend_ok  <= vend_ok_nxt;
    end
  end

  assign disp_req = (state == ST_DISPENSE);
  assign chg_req  = (state == ST_CHANGE) && (credit != '0);
  assign busy     = (state == ST_DISPENSE) || (state == ST_CHANGE);

endmodule
